// File: rtl/loop_nest_pkg.sv
// rtl/loop_nest_pkg.sv - shared state encoding and index-width helper for loop_nest_counter
//
// Contents:
//   S_IDLE / S_RUN   one-bit state encodings shared by the counter FSM
//   state_t          enum built on those encodings
//   idx_width()      bits needed to hold indices 0..max_bound (never below 1)
package loop_nest_pkg;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    typedef enum logic {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN
    } state_t;

    function automatic int idx_width(input int max_bound);
        return (max_bound < 2) ? 1 : $clog2(max_bound + 1);
    endfunction

endpackage

// File: rtl/loop_nest_stage.sv
// rtl/loop_nest_stage.sv - one dimension of the nested loop counter (wrapping index register)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   inc        advance this dimension this cycle
//   load_zero  force the index to 0 (abort / end of pass); wins over inc
//   bound      inclusive max index for this dimension
//   idx        current index
//   at_bound   idx == bound; the parent chains this into the next stage's inc
module loop_nest_stage #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         load_zero,
    input  logic [W-1:0] bound,
    output logic [W-1:0] idx,
    output logic         at_bound
);

    assign at_bound = (idx == bound);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (load_zero) begin
            idx <= '0;
        end else if (inc) begin
            // Wrapping at the bound (not at 2^W) keeps idx <= bound always.
            idx <= at_bound ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/loop_nest_counter.sv
// rtl/loop_nest_counter.sv - NUM_DIMS nested loop index generator with start/busy/done handshake
//
// Optional feature macro: LOOP_NEST_COUNTER_AUTO_RESTART_EN
//   defined   : a completed pass restarts at index 0 with the latched bounds; exit via clear/reset
//   undefined : single pass, return to IDLE after the final tuple is consumed
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   start  begin a pass (sampled in IDLE only)
//   bound  packed inclusive max index per dim, dim d at [d*W +: W]; latched on accepted start
//   adv    advance the tuple this cycle (0 = stall)
//   clear  synchronous abort to IDLE, priority over adv and start
//   idx    current index tuple, same packing as bound
//   wrap   wrap[d] = dim d wraps on this advance
//   last   current tuple is the final one
//   busy   pass in progress
//   done   one-cycle pulse after the final tuple is consumed
module loop_nest_counter
    import loop_nest_pkg::*;
#(
    parameter  int NUM_DIMS  = 3,
    parameter  int MAX_BOUND = 15,
    localparam int W         = idx_width(MAX_BOUND)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_DIMS*W-1:0] bound,
    input  logic                  adv,
    input  logic                  clear,
    output logic [NUM_DIMS*W-1:0] idx,
    output logic [NUM_DIMS-1:0]   wrap,
    output logic                  last,
    output logic                  busy,
    output logic                  done
);

    state_t                  state;
    logic [NUM_DIMS*W-1:0]   bnd;
    logic [NUM_DIMS-1:0]     at_bound;
    logic [NUM_DIMS-1:0]     inc;
    logic [NUM_DIMS:0]       chain;
    logic                    adv_en;
    logic                    finish;
    logic                    load_zero;

    // chain[d] = all dims below d sit at their bound; chain[NUM_DIMS] = final tuple.
    always_comb begin
        chain    = '0;
        chain[0] = 1'b1;
        for (int d = 0; d < NUM_DIMS; d++) begin
            chain[d+1] = chain[d] & at_bound[d];
        end
    end

    assign busy      = (state == ST_RUN);
    assign adv_en    = busy & adv & ~clear;
    assign last      = busy & chain[NUM_DIMS];
    assign finish    = adv_en & chain[NUM_DIMS];
    assign load_zero = (busy & clear) | finish;

    always_comb begin
        inc  = '0;
        wrap = '0;
        for (int d = 0; d < NUM_DIMS; d++) begin
            inc[d]  = adv_en & chain[d];
            wrap[d] = busy & adv & chain[d+1];
        end
    end

    for (genvar d = 0; d < NUM_DIMS; d++) begin : g_dim
        loop_nest_stage #(
            .W (W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc[d]),
            .load_zero (load_zero),
            .bound     (bnd[d*W +: W]),
            .idx       (idx[d*W +: W]),
            .at_bound  (at_bound[d])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            bnd   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !clear) begin
                        state <= ST_RUN;
                        bnd   <= bound;
                    end
                end
                ST_RUN: begin
                    if (clear) begin
                        state <= ST_IDLE;
                    end else if (finish) begin
                        done <= 1'b1;
`ifdef LOOP_NEST_COUNTER_AUTO_RESTART_EN
                        state <= ST_RUN;
`else
                        state <= ST_IDLE;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_loop_nest_counter.sv
// tb/tb_loop_nest_counter.sv - self-checking bench for loop_nest_counter
module tb_loop_nest_counter;

    localparam int ND = 3;
    localparam int W  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            adv = 1'b0;
    logic            clear = 1'b0;
    logic [ND*W-1:0] bound = '0;
    logic [ND*W-1:0] idx;
    logic [ND-1:0]   wrap;
    logic            last;
    logic            busy;
    logic            done;

    always #5 clk = ~clk;

    loop_nest_counter #(
        .NUM_DIMS  (ND),
        .MAX_BOUND (15)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bound (bound),
        .adv   (adv),
        .clear (clear),
        .idx   (idx),
        .wrap  (wrap),
        .last  (last),
        .busy  (busy),
        .done  (done)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ND*W-1:0] idx;
        logic [ND-1:0]   wrap;
        logic            last;
        logic            busy;
        logic            done;
    } exp_t;

    exp_t sbq[$];

    typedef struct {
        logic [ND*W-1:0] bnd;
        int              mode;      // 0 = adv every cycle, 1 = adv on odd cycles
        int              tuples;
        int              cycles;
        int              w0;
        int              w1;
        int              w2;
    } vec_t;

    vec_t vecs[5];

    // Reference model: linear tuple number plus mixed-radix decode.
    bit m_busy;
    bit m_done;
    int m_n;
    int m_b[ND];

    function automatic int m_total();
        int t = 1;
        for (int d = 0; d < ND; d++) t = t * (m_b[d] + 1);
        return t;
    endfunction

    function automatic exp_t m_expect(input logic a);
        exp_t e;
        int   div = 1;
        e.idx  = '0;
        e.wrap = '0;
        for (int d = 0; d < ND; d++) begin
            if (m_busy) e.idx[d*W +: W] = W'((m_n / div) % (m_b[d] + 1));
            div = div * (m_b[d] + 1);
            e.wrap[d] = m_busy && a && (((m_n + 1) % div) == 0);
        end
        e.last = m_busy && (m_n == m_total() - 1);
        e.busy = m_busy;
        e.done = m_done;
        return e;
    endfunction

    task automatic m_reset();
        m_busy = 0;
        m_done = 0;
        m_n    = 0;
        for (int d = 0; d < ND; d++) m_b[d] = 0;
    endtask

    task automatic m_step(input logic s, input logic [ND*W-1:0] b, input logic a, input logic c);
        if (!m_busy) begin
            m_done = 0;
            if (s && !c) begin
                m_busy = 1;
                m_n    = 0;
                for (int d = 0; d < ND; d++) m_b[d] = int'(b[d*W +: W]);
            end
        end else if (c) begin
            m_busy = 0;
            m_n    = 0;
            m_done = 0;
        end else if (a) begin
            if (m_n == m_total() - 1) begin
                m_n    = 0;
                m_done = 1;
`ifndef LOOP_NEST_COUNTER_AUTO_RESTART_EN
                m_busy = 0;
`endif
            end else begin
                m_n    = m_n + 1;
                m_done = 0;
            end
        end else begin
            m_done = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
        end
    endtask

    logic [ND*W-1:0] s_idx;
    logic [ND-1:0]   s_wrap;
    logic            s_last;
    logic            s_busy;
    logic            s_done;

    // One clock cycle: drive, push expectation, compare at negedge, step model.
    task automatic tick(input logic s, input logic [ND*W-1:0] b, input logic a, input logic c);
        exp_t e;
        start = s;
        bound = b;
        adv   = a;
        clear = c;
        sbq.push_back(m_expect(a));
        @(negedge clk);
        e      = sbq.pop_front();
        s_idx  = idx;
        s_wrap = wrap;
        s_last = last;
        s_busy = busy;
        s_done = done;
        check("idx",  32'(idx),  32'(e.idx));
        check("wrap", 32'(wrap), 32'(e.wrap));
        check("last", 32'(last), 32'(e.last));
        check("busy", 32'(busy), 32'(e.busy));
        check("done", 32'(done), 32'(e.done));
        @(posedge clk);
        m_step(s, b, a, c);
        #1;
    endtask

    task automatic run_pass(input int r, input vec_t v);
        int              tuples = 0;
        int              cycles = 0;
        int              w[ND];
        logic [ND*W-1:0] last_tuple = '0;
        bit              seen = 0;
        logic            a;
        for (int d = 0; d < ND; d++) w[d] = 0;
        tick(1'b1, v.bnd, 1'b0, 1'b0);
        for (int k = 0; k < 400; k++) begin
            a = (v.mode == 0) || (k % 2 == 1);
            // Bound input changes freely while busy; only the latched copy matters.
            tick(1'b0, 12'($urandom), a, 1'b0);
            if (s_done) begin
                seen = 1;
                break;
            end
            if (s_busy) cycles++;
            if (s_busy && a) tuples++;
            for (int d = 0; d < ND; d++) if (s_wrap[d]) w[d]++;
            if (s_last && a) last_tuple = s_idx;
        end
        check($sformatf("row%0d_done_seen", r), 32'(seen), 32'd1);
        check($sformatf("row%0d_tuples", r), tuples, v.tuples);
        check($sformatf("row%0d_cycles", r), cycles, v.cycles);
        check($sformatf("row%0d_wrap0", r), w[0], v.w0);
        check($sformatf("row%0d_wrap1", r), w[1], v.w1);
        check($sformatf("row%0d_wrap2", r), w[2], v.w2);
        check($sformatf("row%0d_last_tuple", r), 32'(last_tuple), 32'(v.bnd));
`ifndef LOOP_NEST_COUNTER_AUTO_RESTART_EN
        check($sformatf("row%0d_busy_at_done", r), 32'(s_busy), 32'd0);
`endif
        tick(1'b0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b0);
        check($sformatf("row%0d_idle_after", r), 32'(s_busy), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 300000", $time);
        $fatal(1);
    end

    initial begin
        int dcnt;
        int idle_cnt;

        vecs[0] = '{bnd: 12'h123, mode: 0, tuples: 24, cycles: 24, w0: 6, w1: 2, w2: 1};
        vecs[1] = '{bnd: 12'h123, mode: 1, tuples: 24, cycles: 48, w0: 6, w1: 2, w2: 1};
        vecs[2] = '{bnd: 12'h000, mode: 0, tuples: 1,  cycles: 1,  w0: 1, w1: 1, w2: 1};
        vecs[3] = '{bnd: 12'h204, mode: 0, tuples: 15, cycles: 15, w0: 3, w1: 3, w2: 1};
        vecs[4] = '{bnd: 12'h00f, mode: 0, tuples: 16, cycles: 16, w0: 1, w1: 1, w2: 1};

        m_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_idx",  32'(idx),  32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_wrap", 32'(wrap), 32'd0);
        check("reset_last", 32'(last), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) tick(1'b0, 12'h123, 1'b1, 1'b0);

        for (int r = 0; r < 5; r++) run_pass(r, vecs[r]);

        // Reset mid-run after five advances.
        tick(1'b1, 12'h123, 1'b0, 1'b0);
        repeat (5) tick(1'b0, 12'h123, 1'b1, 1'b0);
        check("pre_reset_idx", 32'(idx), 32'h011);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_idx",  32'(idx),  32'd0);
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_done", 32'(done), 32'd0);
        sbq.delete();
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) tick(1'b0, 12'h123, 1'b1, 1'b0);
        check("idle_after_reset", 32'(s_busy), 32'd0);

        // Clear on tuple 10, with a start in the same cycle.
        tick(1'b1, 12'h123, 1'b0, 1'b0);
        repeat (10) tick(1'b0, 12'h123, 1'b1, 1'b0);
        check("tuple10_idx", 32'(idx), 32'h022);
        tick(1'b1, 12'h123, 1'b1, 1'b1);
        check("clear_cycle_busy", 32'(s_busy), 32'd1);
        tick(1'b0, 12'h123, 1'b0, 1'b0);
        check("after_clear_busy", 32'(s_busy), 32'd0);
        check("after_clear_idx",  32'(s_idx),  32'd0);
        check("after_clear_done", 32'(s_done), 32'd0);
        dcnt = 0;
        repeat (3) begin
            tick(1'b0, 12'h123, 1'b1, 1'b0);
            if (s_done) dcnt++;
        end
        check("no_done_after_clear", dcnt, 0);

        // Start accepted in the done cycle of a one-tuple pass.
        tick(1'b1, 12'h000, 1'b0, 1'b0);
        tick(1'b0, 12'h000, 1'b1, 1'b0);
        check("single_tuple_last", 32'(s_last), 32'd1);
        tick(1'b1, 12'h001, 1'b0, 1'b0);
        check("done_cycle_done", 32'(s_done), 32'd1);
        tick(1'b0, 12'h001, 1'b0, 1'b0);
        check("restart_busy", 32'(s_busy), 32'd1);
        check("restart_idx",  32'(s_idx),  32'd0);
        tick(1'b0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b0);

`ifdef LOOP_NEST_COUNTER_AUTO_RESTART_EN
        tick(1'b1, 12'h011, 1'b0, 1'b0);
        dcnt     = 0;
        idle_cnt = 0;
        repeat (13) begin
            tick(1'b0, 12'h011, 1'b1, 1'b0);
            if (s_done) dcnt++;
            if (!s_busy) idle_cnt++;
        end
        check("auto_done_pulses", dcnt, 3);
        check("auto_idle_cycles", idle_cnt, 0);
        tick(1'b0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b0);
        check("auto_clear_busy", 32'(s_busy), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
